// File: rtl/bicubic_vector_mult_pipe_pkg.sv
// bicubic_pkg: coefficient table, code decode and parameter presets
// shared by the bicubic vector multiply pipeline and its channel datapath.
package bicubic_pkg;

  localparam int COEF_WIDTH      = 9;
  localparam int COEF_SCALE_LOG2 = 7;
  localparam int CODE_WIDTH      = 3;

  typedef logic signed [COEF_WIDTH-1:0] coef_t;
  typedef logic [CODE_WIDTH-1:0]        code_t;

  typedef struct packed {
    int taps;
    int channels;
    int in_width;
    int in_signed;
    int shift;
    int sat;
    int out_width;
  } preset_t;

  // Horizontal pass keeps full precision, vertical pass produces 8-bit pixels.
  localparam preset_t STAGE1_PRESET = '{
    taps: 4, channels: 3, in_width: 8, in_signed: 0,
    shift: 0, sat: 0, out_width: 19
  };
  localparam preset_t STAGE2_PRESET = '{
    taps: 4, channels: 3, in_width: 19, in_signed: 1,
    shift: 2 * COEF_SCALE_LOG2, sat: 1, out_width: 8
  };

  function automatic coef_t coef_decode(input code_t code);
    coef_t c;
    c = '0;
    unique case (code)
      3'd0: c = 9'sd0;
      3'd1: c = -9'sd9;
      3'd2: c = 9'sd111;
      3'd3: c = 9'sd29;
      3'd4: c = -9'sd3;
      3'd5: c = -9'sd8;
      3'd6: c = 9'sd72;
      3'd7: c = 9'sd128;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bicubic_vector_mult_pipe_if.sv
// Stream bundle for the bicubic vector multiply pipeline:
// weight/pixel/tag beats in, per-channel results out.
interface bicubic_vector_mult_pipe_if
  import bicubic_pkg::*;
#(
  parameter int TAPS       = 4,
  parameter int CHANNELS   = 3,
  parameter int IN_WIDTH   = 19,
  parameter int OUT_WIDTH  = 8,
  parameter int USER_WIDTH = 2
);

  logic                             in_valid;
  logic                             in_ready;
  logic [TAPS*CODE_WIDTH-1:0]       in_weight;
  logic [CHANNELS*TAPS*IN_WIDTH-1:0] in_pixel;
  logic [USER_WIDTH-1:0]            in_user;
  logic                             out_valid;
  logic                             out_ready;
  logic [CHANNELS*OUT_WIDTH-1:0]    out_data;
  logic [USER_WIDTH-1:0]            out_user;
  logic [CHANNELS-1:0]              out_sat;

  modport master (
    output in_valid, in_weight, in_pixel, in_user,
    output out_ready,
    input  in_ready,
    input  out_valid, out_data, out_user, out_sat
  );

  modport slave (
    input  in_valid, in_weight, in_pixel, in_user,
    input  out_ready,
    output in_ready,
    output out_valid, out_data, out_user, out_sat
  );

endinterface

// File: rtl/bicubic_vector_mult_pipe_dot.sv
// bicubic_channel_dot: one channel's products, registered adder tree
// and round/shift/saturate stage, all advanced by the shared enable.
module bicubic_channel_dot
  import bicubic_pkg::*;
#(
  parameter int TAPS      = 4,
  parameter int IN_WIDTH  = 19,
  parameter int IN_SIGNED = 1,
  parameter int SHIFT     = 14,
  parameter int SAT       = 1,
  parameter int OUT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       load,
  input  logic [TAPS*CODE_WIDTH-1:0] weight,
  input  logic [TAPS*IN_WIDTH-1:0]   pixel,
  output logic [OUT_WIDTH-1:0]       data,
  output logic                       sat
);

  localparam int PW = IN_WIDTH + 1 + COEF_WIDTH;
  localparam int AW = PW + $clog2(TAPS);
  localparam int HS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [AW-1:0] HALF =
    AW'(SHIFT > 0) << HS;

  logic signed [AW-1:0]  px   [TAPS];
  logic signed [AW-1:0]  cf   [TAPS];
  // Heap-ordered tree: leaves hold products, node 0 is the sum.
  logic signed [AW-1:0]  node [2*TAPS-1];
  logic signed [AW-1:0]  rnd;
  logic signed [AW-1:0]  r;
  logic [AW-OUT_WIDTH:0] hi;
  logic [OUT_WIDTH-1:0]  d_nxt;
  logic                  s_nxt;

  always_comb begin
    for (int t = 0; t < TAPS; t++) begin
      if (IN_SIGNED != 0)
        px[t] = AW'($signed(pixel[t*IN_WIDTH +: IN_WIDTH]));
      else
        px[t] = AW'(pixel[t*IN_WIDTH +: IN_WIDTH]);
      cf[t] = AW'(coef_decode(
        weight[t*CODE_WIDTH +: CODE_WIDTH]));
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int t = 0; t < TAPS; t++)
        node[TAPS-1+t] <= px[t] * cf[t];
      for (int j = 0; j < TAPS - 1; j++)
        node[j] <= node[2*j+1] + node[2*j+2];
    end
  end

  always_comb begin
    rnd   = node[0] + HALF;
    r     = rnd >>> SHIFT;
    hi    = r[AW-1:OUT_WIDTH-1];
    d_nxt = r[OUT_WIDTH-1:0];
    s_nxt = 1'b0;
    if (SAT != 0) begin
      if (r[AW-1]) begin
        d_nxt = '0;
        s_nxt = 1'b1;
      end else if (|hi[AW-OUT_WIDTH:1]) begin
        d_nxt = '1;
        s_nxt = 1'b1;
      end
    end else begin
      s_nxt = !((&hi) || !(|hi));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      sat  <= 1'b0;
    end else if (load) begin
      data <= d_nxt;
      sat  <= s_nxt;
    end
  end

endmodule

// File: rtl/bicubic_vector_mult_pipe.sv
// bicubic_vector_mult_pipe: CHANNELS parallel TAPS-wide dot products
// behind a stall-everything valid/ready pipeline with a sideband tag.
module bicubic_vector_mult_pipe
  import bicubic_pkg::*;
#(
  parameter int TAPS       = 4,
  parameter int CHANNELS   = 3,
  parameter int IN_WIDTH   = 19,
  parameter int IN_SIGNED  = 1,
  parameter int SHIFT      = 14,
  parameter int SAT        = 1,
  parameter int OUT_WIDTH  = 8,
  parameter int USER_WIDTH = 2
) (
  input logic clk,
  input logic rst_n,
  bicubic_vector_mult_pipe_if.slave bus
);

  localparam int NS = $clog2(TAPS) + 1;

  logic                          en;
  logic                          load;
  logic [NS-1:0]                 vld;
  logic                          ov;
  logic [USER_WIDTH-1:0]         usr [NS];
  logic [USER_WIDTH-1:0]         uo;
  logic [CHANNELS*OUT_WIDTH-1:0] dat;
  logic [CHANNELS-1:0]           st;

  assign en   = !ov || bus.out_ready;
  assign load = en && vld[NS-1];

  assign bus.in_ready  = en;
  assign bus.out_valid = ov;
  assign bus.out_user  = uo;
  assign bus.out_data  = dat;
  assign bus.out_sat   = st;

  // Bubbles travel as vld=0 so occupancy only changes at the ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      ov  <= 1'b0;
      uo  <= '0;
    end else if (en) begin
      vld <= {vld[NS-2:0], bus.in_valid};
      ov  <= vld[NS-1];
      if (vld[NS-1])
        uo <= usr[NS-1];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      usr[0] <= bus.in_user;
      for (int i = 1; i < NS; i++)
        usr[i] <= usr[i-1];
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    bicubic_channel_dot #(
      .TAPS      (TAPS),
      .IN_WIDTH  (IN_WIDTH),
      .IN_SIGNED (IN_SIGNED),
      .SHIFT     (SHIFT),
      .SAT       (SAT),
      .OUT_WIDTH (OUT_WIDTH)
    ) u_dot (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .load   (load),
      .weight (bus.in_weight),
      .pixel  (bus.in_pixel[c*TAPS*IN_WIDTH +: TAPS*IN_WIDTH]),
      .data   (dat[c*OUT_WIDTH +: OUT_WIDTH]),
      .sat    (st[c])
    );
  end

endmodule

// File: tb/tb_bicubic_vector_mult_pipe.sv
// Bench for bicubic_vector_mult_pipe: vector table, scoreboard,
// backpressure, mid-flight reset and the stage-1 preset.
module tb_bicubic_vector_mult_pipe;
  import bicubic_pkg::*;

  localparam int TAPS = 4;
  localparam int CH   = 3;
  localparam int IW   = 19;
  localparam int OW   = 8;
  localparam int UW   = 2;
  localparam int WW   = TAPS * 3;
  localparam int PXW  = CH * TAPS * IW;
  localparam int NV   = 11;

  typedef struct packed {
    logic [CH*OW-1:0] d;
    logic [CH-1:0]    s;
    logic [UW-1:0]    u;
  } sb_t;

  typedef struct {
    int code [TAPS];
    int pix  [TAPS];
    int exp_d;
    int exp_s;
  } vec_t;

  logic clk;
  logic rst_n;
  int   nchk;
  int   nerr;
  bit   bp;
  bit   stall_prev;
  sb_t  held;
  sb_t  sbq [$];
  vec_t vt [NV];

  bicubic_vector_mult_pipe_if #(
    .TAPS(TAPS), .CHANNELS(CH), .IN_WIDTH(IW),
    .OUT_WIDTH(OW), .USER_WIDTH(UW)
  ) bus ();

  bicubic_vector_mult_pipe_if #(
    .TAPS(4), .CHANNELS(3), .IN_WIDTH(8),
    .OUT_WIDTH(19), .USER_WIDTH(2)
  ) bus1 ();

  bicubic_vector_mult_pipe #(
    .TAPS(TAPS), .CHANNELS(CH), .IN_WIDTH(IW),
    .IN_SIGNED(1), .SHIFT(14), .SAT(1),
    .OUT_WIDTH(OW), .USER_WIDTH(UW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  bicubic_vector_mult_pipe #(
    .TAPS(4), .CHANNELS(3), .IN_WIDTH(8),
    .IN_SIGNED(0), .SHIFT(0), .SAT(0),
    .OUT_WIDTH(19), .USER_WIDTH(2)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int coef(input int code);
    case (code)
      0: return 0;
      1: return -9;
      2: return 111;
      3: return 29;
      4: return -3;
      5: return -8;
      6: return 72;
      7: return 128;
      default: return 0;
    endcase
  endfunction

  function automatic vec_t mk(
    input int c0, c1, c2, c3,
    input int p0, p1, p2, p3,
    input int d, s);
    vec_t v;
    v.code = '{c0, c1, c2, c3};
    v.pix  = '{p0, p1, p2, p3};
    v.exp_d = d;
    v.exp_s = s;
    return v;
  endfunction

  function automatic logic [WW-1:0] pack_w(input int c [TAPS]);
    logic [WW-1:0] w;
    for (int t = 0; t < TAPS; t++)
      w[3*t +: 3] = 3'(c[t]);
    return w;
  endfunction

  function automatic logic [PXW-1:0] pack_px(input int p [TAPS]);
    logic [PXW-1:0] v;
    for (int c = 0; c < CH; c++)
      for (int t = 0; t < TAPS; t++)
        v[(c*TAPS+t)*IW +: IW] = IW'(p[t]);
    return v;
  endfunction

  function automatic sb_t rep(input int d, s, u);
    sb_t e;
    for (int c = 0; c < CH; c++) begin
      e.d[c*OW +: OW] = OW'(d);
      e.s[c] = 1'(s);
    end
    e.u = UW'(u);
    return e;
  endfunction

  function automatic sb_t model(
    input logic [WW-1:0] w,
    input logic [PXW-1:0] p,
    input logic [UW-1:0] u);
    sb_t e;
    longint acc;
    longint r;
    for (int c = 0; c < CH; c++) begin
      acc = 0;
      for (int t = 0; t < TAPS; t++)
        acc += longint'($signed(p[(c*TAPS+t)*IW +: IW]))
             * coef(int'(w[3*t +: 3]));
      r = (acc + 8192) >>> 14;
      if (r < 0) begin
        e.d[c*OW +: OW] = '0;
        e.s[c] = 1'b1;
      end else if (r > 255) begin
        e.d[c*OW +: OW] = '1;
        e.s[c] = 1'b1;
      end else begin
        e.d[c*OW +: OW] = OW'(r);
        e.s[c] = 1'b0;
      end
    end
    e.u = u;
    return e;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // One clock cycle: handshake bookkeeping, then advance.
  task automatic tick(input sb_t e, output bit acc);
    sb_t x;
    bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (stall_prev)
      chk("stall_hold",
          {bus.out_valid, bus.out_data, bus.out_sat, bus.out_user},
          {1'b1, held});
    if (bus.out_valid && !bus.out_ready) begin
      chk("stall_in_ready", bus.in_ready, 0);
      stall_prev = 1'b1;
      held = '{d: bus.out_data, s: bus.out_sat, u: bus.out_user};
    end else begin
      chk("in_ready_open", bus.in_ready, 1);
      stall_prev = 1'b0;
    end
    if (bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_out: got data 0x%0h, expected none",
                 bus.out_data);
      end else begin
        x = sbq.pop_front();
        chk("out_data", bus.out_data, x.d);
        chk("out_sat", bus.out_sat, x.s);
        chk("out_user", bus.out_user, x.u);
      end
    end
    acc = bus.in_valid && bus.in_ready;
    if (acc) sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WW-1:0] w,
                      input logic [PXW-1:0] p,
                      input logic [UW-1:0] u,
                      input sb_t e);
    bit a;
    int g;
    bus.in_valid  = 1'b1;
    bus.in_weight = w;
    bus.in_pixel  = p;
    bus.in_user   = u;
    a = 1'b0;
    g = 0;
    while (!a && g < 200) begin
      tick(e, a);
      g++;
    end
    chk("send_accept", a, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit a;
    int g;
    g = 0;
    while (sbq.size() > 0 && g < 400) begin
      tick('0, a);
      g++;
    end
    chk("drain_empty", sbq.size(), 0);
  endtask

  initial begin
    bit a;
    int lat;
    int seen;
    int cs [TAPS];
    logic [WW-1:0]  w;
    logic [PXW-1:0] p;

    nchk = 0;
    nerr = 0;
    bp = 1'b0;
    stall_prev = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_weight = '0;
    bus.in_pixel = '0;
    bus.in_user = '0;
    bus.out_ready = 1'b1;
    bus1.in_valid = 1'b0;
    bus1.in_weight = '0;
    bus1.in_pixel = '0;
    bus1.in_user = '0;
    bus1.out_ready = 1'b1;

    vt[0]  = mk(1,2,3,4, 16384,16384,16384,16384, 128,0);
    vt[1]  = mk(7,0,0,0, 64,0,0,0, 1,0);
    vt[2]  = mk(7,0,0,0, 63,0,0,0, 0,0);
    vt[3]  = mk(5,6,6,5, 0,32640,32640,0, 255,1);
    vt[4]  = mk(5,6,6,5, 32640,0,0,32640, 0,1);
    vt[5]  = mk(1,2,3,4, -16384,-16384,-16384,-16384, 0,1);
    vt[6]  = mk(7,0,0,0, 32640,0,0,0, 255,0);
    vt[7]  = mk(7,0,0,0, 32768,0,0,0, 255,1);
    vt[8]  = mk(7,0,0,0, -64,0,0,0, 0,0);
    vt[9]  = mk(7,0,0,0, -65,0,0,0, 0,1);
    vt[10] = mk(0,2,6,3, 100000,50,-20,1000, 2,0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_user", bus.out_user, 0);
    chk("rst_out_sat", bus.out_sat, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(pack_w(vt[0].code), pack_px(vt[0].pix), 2'd1,
         rep(128, 0, 1));
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      tick('0, a);
      lat++;
    end
    chk("unity_latency", lat, 4);
    drain();

    for (int i = 0; i < NV; i++)
      send(pack_w(vt[i].code), pack_px(vt[i].pix), UW'(i),
           rep(vt[i].exp_d, vt[i].exp_s, i % 4));
    drain();

    bp = 1'b1;
    for (int i = 0; i < 10; i++) begin
      w = WW'($urandom);
      for (int c = 0; c < CH; c++)
        for (int t = 0; t < TAPS; t++)
          p[(c*TAPS+t)*IW +: IW] =
            IW'(int'($urandom_range(0, 48000)) - 8000);
      send(w, p, UW'(i), model(w, p, UW'(i)));
    end
    drain();
    bp = 1'b0;

    for (int i = 0; i < 3; i++)
      send(pack_w(vt[0].code), pack_px(vt[0].pix), UW'(i),
           rep(128, 0, i));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sbq.delete();
    stall_prev = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid) seen++;
      tick('0, a);
    end
    chk("midrst_silent", seen, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    send(pack_w(vt[1].code), pack_px(vt[1].pix), 2'd3,
         rep(1, 0, 3));
    drain();

    cs = '{5, 6, 6, 5};
    bus1.in_weight = pack_w(cs);
    bus1.in_pixel = '1;
    bus1.in_user = 2'd2;
    bus1.in_valid = 1'b1;
    #1;
    chk("s1_in_ready", bus1.in_ready, 1);
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    lat = 1;
    while (!bus1.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("s1_latency", lat, 4);
    for (int c = 0; c < 3; c++)
      chk("s1_data", bus1.out_data[c*19 +: 19], 32640);
    chk("s1_sat", bus1.out_sat, 0);
    chk("s1_user", bus1.out_user, 2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
